cache_refill_ctrl: RTL and testbench

// Backing-memory controller directly downstream of the cache. On a cache read miss or write-through the

---
 rtl/cache_refill_ctrl.sv | 153 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: main-memory model sitting below the cache. Accepts one
// read-refill or write-through request at a time, waits MEM_LATENCY cycles,
// performs the access and pulses respValid with the result.
module cache_refill_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqValue,
    output logic        reqReady,
    output logic        respValid,
    output logic        respWrite,
    output logic [31:0] respAddress,
    output logic [31:0] respData,
    output logic        busy,
    output logic [15:0] missCount
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   value_q, value_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_write_q, resp_write_d;
    logic [31:0]   resp_address_q, resp_address_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          busy_q, busy_d;
    logic [15:0]   miss_count_q, miss_count_d;

    // The array holds each word XOR-ed with its power-on image (index*5), so a
    // zero-initialised array reads back as mem[i] = i*5 without any preload.
    logic [31:0]          mem_q [DEPTH];
    logic                 mem_we;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          mem_rdata;

    function automatic logic [31:0] power_on_word(input logic [ADDR_BITS-1:0] i);
        return 32'(i) * 32'd5;
    endfunction

    // Upper address bits and the byte offset are dropped, so addresses alias.
    assign idx       = addr_q[ADDR_BITS+1:2];
    assign mem_rdata = mem_q[idx] ^ power_on_word(idx);

    // Next-state, latency count, request capture and response/result selection.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        value_d        = value_q;
        resp_write_d   = resp_write_q;
        resp_address_d = resp_address_q;
        resp_data_d    = resp_data_q;
        miss_count_d   = miss_count_q;
        mem_we         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reqValid && req_ready_q) begin
                    state_d = ACCESS;
                    wr_d    = reqWrite;
                    addr_d  = reqAddress;
                    value_d = reqValue;
                    cnt_d   = 8'(MEM_LATENCY - 1);
                    if (!reqWrite && miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    mem_we         = wr_q;
                    resp_write_d   = wr_q;
                    resp_address_d = addr_q;
                    resp_data_d    = wr_q ? value_q : mem_rdata;
                    state_d        = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // FSM and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            wr_q           <= 1'b0;
            addr_q         <= 32'd0;
            value_q        <= 32'd0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_write_q   <= 1'b0;
            resp_address_q <= 32'd0;
            resp_data_q    <= 32'd0;
            busy_q         <= 1'b0;
            miss_count_q   <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            value_q        <= value_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_write_q   <= resp_write_d;
            resp_address_q <= resp_address_d;
            resp_data_q    <= resp_data_d;
            busy_q         <= busy_d;
            miss_count_q   <= miss_count_d;
        end
    end

    // Memory array commits writes at the end of ACCESS; reset never touches it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= value_q ^ power_on_word(idx);
        end
    end

    assign reqReady    = req_ready_q;
    assign respValid   = resp_valid_q;
    assign respWrite   = resp_write_q;
    assign respAddress = resp_address_q;
    assign respData    = resp_data_q;
    assign busy        = busy_q;
    assign missCount   = miss_count_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: two instances (MEM_LATENCY 4 and 1) driven by directed
// requests; expected responses are queued at issue time and checked by a
// monitor whenever respValid appears.
module tb_cache_refill_ctrl;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  reqValid = 2'b00;
    logic [1:0]  reqWrite = 2'b00;
    logic [31:0] reqAddress [2];
    logic [31:0] reqValue [2];
    logic [1:0]  reqReady;
    logic [1:0]  respValid;
    logic [1:0]  respWrite;
    logic [1:0]  busy;
    logic [31:0] respAddress [2];
    logic [31:0] respData [2];
    logic [15:0] missCount [2];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] miss;
        int          respEdge;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] missExp [2];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    cache_refill_ctrl #(.MEM_LATENCY(LAT0), .ADDR_BITS(10)) dut0 (
        .clk(clk), .reset(reset),
        .reqValid(reqValid[0]), .reqWrite(reqWrite[0]),
        .reqAddress(reqAddress[0]), .reqValue(reqValue[0]),
        .reqReady(reqReady[0]), .respValid(respValid[0]), .respWrite(respWrite[0]),
        .respAddress(respAddress[0]), .respData(respData[0]),
        .busy(busy[0]), .missCount(missCount[0])
    );

    cache_refill_ctrl #(.MEM_LATENCY(LAT1), .ADDR_BITS(10)) dut1 (
        .clk(clk), .reset(reset),
        .reqValid(reqValid[1]), .reqWrite(reqWrite[1]),
        .reqAddress(reqAddress[1]), .reqValue(reqValue[1]),
        .reqReady(reqReady[1]), .respValid(respValid[1]), .respWrite(respWrite[1]),
        .respAddress(respAddress[1]), .respData(respData[1]),
        .busy(busy[1]), .missCount(missCount[1])
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter: after posedge N the value is N, used to check response timing.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int sel);
        return (sel == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int qSize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pushExp(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        vectors++;
        if (act !== expVal) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expVal);
        end
    endtask

    task automatic flagFail(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out, expected event did not occur", name);
    endtask

    // Pops one expectation per respValid pulse and compares every response field.
    task automatic checkResp(input int s);
        exp_t e;
        if (respValid[s] === 1'b1) begin
            if (qSize(s) == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_resp%0d: got respValid=1 addr=0x%0h, expected no response",
                         s, respAddress[s]);
            end else begin
                e = (s == 0) ? q0.pop_front() : q1.pop_front();
                checkOutput($sformatf("respWrite%0d", s),   32'(respWrite[s]), 32'(e.wr));
                checkOutput($sformatf("respAddress%0d", s), respAddress[s],    e.addr);
                checkOutput($sformatf("respData%0d", s),    respData[s],       e.data);
                checkOutput($sformatf("missCount%0d", s),   32'(missCount[s]), 32'(e.miss));
                checkOutput($sformatf("respEdge%0d", s),    32'(cyc),          32'(e.respEdge));
            end
        end
    endtask

    // Monitor: samples both instances on the falling edge, away from updates.
    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) checkResp(s);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitIdle(input int sel);
        int n = 0;
        while (qSize(sel) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) flagFail($sformatf("response%0d", sel));
        @(negedge clk);
    endtask

    task automatic waitReady(input int sel, output bit ok);
        int n = 0;
        while (reqReady[sel] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        if (!ok) flagFail($sformatf("accept%0d", sel));
    endtask

    // Single request: queue its expected response, then scramble the request
    // inputs to show the in-flight transaction was latched.
    task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] val, input logic [31:0] expData);
        exp_t e;
        bit   ok;
        @(negedge clk);
        reqValid[sel]   = 1'b1;
        reqWrite[sel]   = wr;
        reqAddress[sel] = addr;
        reqValue[sel]   = val;
        waitReady(sel, ok);
        if (!ok) begin
            reqValid[sel] = 1'b0;
            return;
        end
        if (!wr && missExp[sel] != 16'hFFFF) missExp[sel] = missExp[sel] + 16'd1;
        e.wr = wr; e.addr = addr; e.data = expData; e.miss = missExp[sel];
        e.respEdge = cyc + 1 + lat(sel);
        pushExp(sel, e);
        @(negedge clk);
        reqValid[sel]   = 1'b0;
        reqAddress[sel] = 32'hFFFF_FFFF;
        reqValue[sel]   = 32'hBAD0_BAD0;
        checkOutput($sformatf("busyAccess%0d", sel),  32'(busy[sel]),     32'd1);
        checkOutput($sformatf("readyAccess%0d", sel), 32'(reqReady[sel]), 32'd0);
        waitIdle(sel);
    endtask

    // reqValid held high: acceptances must be exactly MEM_LATENCY+2 cycles apart.
    task automatic holdReads(input int sel, input logic [31:0] addr, input logic [31:0] expData, input int n);
        exp_t e;
        bit   ok;
        int   first;
        @(negedge clk);
        reqValid[sel]   = 1'b1;
        reqWrite[sel]   = 1'b0;
        reqAddress[sel] = addr;
        reqValue[sel]   = 32'd0;
        waitReady(sel, ok);
        if (!ok) begin
            reqValid[sel] = 1'b0;
            return;
        end
        first = cyc + 1;
        for (int k = 0; k < n; k++) begin
            if (missExp[sel] != 16'hFFFF) missExp[sel] = missExp[sel] + 16'd1;
            e.wr = 1'b0; e.addr = addr; e.data = expData; e.miss = missExp[sel];
            e.respEdge = first + k * (lat(sel) + 2) + lat(sel);
            pushExp(sel, e);
        end
        repeat (1 + (n - 1) * (lat(sel) + 2)) @(posedge clk);
        @(negedge clk);
        reqValid[sel] = 1'b0;
        waitIdle(sel);
    endtask

    // Write accepted, then reset while it is still in ACCESS: no response, no commit.
    task automatic resetDuringWrite(input logic [31:0] addr, input logic [31:0] val);
        bit ok;
        @(negedge clk);
        reqValid[0]   = 1'b1;
        reqWrite[0]   = 1'b1;
        reqAddress[0] = addr;
        reqValue[0]   = val;
        waitReady(0, ok);
        @(negedge clk);
        reqValid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("busyInReset",  32'(busy[0]),      32'd0);
        checkOutput("readyInReset", 32'(reqReady[0]),  32'd1);
        checkOutput("missInReset",  32'(missCount[0]), 32'd0);
        missExp[0] = 16'd0;
        missExp[1] = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        reqAddress[0] = 32'd0; reqAddress[1] = 32'd0;
        reqValue[0]   = 32'd0; reqValue[1]   = 32'd0;
        missExp[0]    = 16'd0; missExp[1]    = 16'd0;

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("rstReady%0d", s),    32'(reqReady[s]),  32'd1);
            checkOutput($sformatf("rstBusy%0d", s),     32'(busy[s]),      32'd0);
            checkOutput($sformatf("rstValid%0d", s),    32'(respValid[s]), 32'd0);
            checkOutput($sformatf("rstMiss%0d", s),     32'(missCount[s]), 32'd0);
            checkOutput($sformatf("rstData%0d", s),     respData[s],       32'd0);
            checkOutput($sformatf("rstAddress%0d", s),  respAddress[s],    32'd0);
        end

        // Plain read refill of word 4.
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 32'd20);

        // Write-through then read back the written word.
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'h0000_DEAD, 32'h0000_DEAD);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 32'h0000_DEAD);

        // Back-to-back reads with reqValid held high.
        holdReads(0, 32'h0000_0008, 32'd10, 3);

        // Reset mid-write, then the word still holds its power-on value.
        resetDuringWrite(32'h0000_0020, 32'h0000_1234);
        applyStimulus(0, 1'b0, 32'h0000_0020, 32'd0, 32'd40);

        // Aliasing and single-cycle latency on the second instance.
        applyStimulus(1, 1'b0, 32'h1000_0010, 32'd0, 32'd20);
        applyStimulus(1, 1'b1, 32'h0000_0004, 32'h0000_0055, 32'h0000_0055);
        applyStimulus(1, 1'b0, 32'h8000_0004, 32'd0, 32'h0000_0055);
        applyStimulus(1, 1'b0, 32'h0000_0FFC, 32'd0, 32'd5115);
        holdReads(1, 32'h0000_0008, 32'd10, 3);

        // Aliased read of a previously written word on the first instance.
        applyStimulus(0, 1'b0, 32'h1000_0013, 32'd0, 32'h0000_DEAD);

        checkOutput("pending0", 32'(qSize(0)), 32'd0);
        checkOutput("pending1", 32'(qSize(1)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
